conv_feature_writer: RTL

Output-side companion of the convolution layer. Captures each completed feature row (ARRAY_SIZE parallel words, tagged with feature index and row) when the layer asserts `valid`, buffers up to two rows, and serializes them one word per cycle into an external feature RAM through a write/ready handshake. Signals `write_fin` once every buffered row has been written after the layer reports `image_calc_fin`.

---
 rtl/conv_feature_writer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/conv_feature_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | conv_feature_writer: buffers up to two completed feature rows and      |
// | serializes them one word per cycle into the feature RAM.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef EXT_ADDR_WIDTH
`define EXT_ADDR_WIDTH 16
`endif

module conv_feature_writer #(
  parameter int ARRAY_SIZE   = 6,
  parameter int ARRAY_WIDTH  = 3,
  parameter int WEIGHT_WIDTH = 2,
  parameter int TOTAL_WEIGHT = 4,
  parameter int BASE_ADDR    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid,
  input  logic [WEIGHT_WIDTH-1:0]           feature_idx,
  input  logic [ARRAY_WIDTH-1:0]            feature_row,
  input  logic [ARRAY_SIZE*`DATA_WIDTH-1:0] feature_output,
  input  logic                              image_calc_fin,
  input  logic                              ram_ready,
  output logic                              ram_we,
  output logic [`EXT_ADDR_WIDTH-1:0]        ram_addr,
  output logic [`DATA_WIDTH-1:0]            ram_data,
  output logic                              busy,
  output logic                              overflow,
  output logic                              write_fin
);

  localparam int DW          = `DATA_WIDTH;
  localparam int AW          = `EXT_ADDR_WIDTH;
  localparam int ROW_W       = ARRAY_SIZE * DW;
  localparam int IMAGE_WORDS = TOTAL_WEIGHT * ARRAY_SIZE * ARRAY_SIZE;
  localparam int SPAN_W      = $clog2(BASE_ADDR + IMAGE_WORDS + 1);
  // Modular arithmetic: any width >= AW yields the same truncated address.
  localparam int CALC_W      = (SPAN_W > AW) ? SPAN_W : AW;

  localparam logic [ARRAY_WIDTH-1:0] LAST_COL = ARRAY_WIDTH'(ARRAY_SIZE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             r_count;
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [ROW_W-1:0]       r_fifo_data [0:1];
  logic [AW-1:0]          r_fifo_base [0:1];
  logic [ROW_W-1:0]       r_shift;
  logic [AW-1:0]          r_row_base;
  logic [ARRAY_WIDTH-1:0] r_col;
  logic                   r_fin_pending;

  logic [CALC_W-1:0]      w_base_calc;
  logic [AW-1:0]          w_base;
  logic [ROW_W-1:0]       w_head_data;
  logic [AW-1:0]          w_head_base;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;
  logic                   w_drop;
  logic [1:0]             w_count_next;
  logic [1:0]             w_state_next;
  logic [ARRAY_WIDTH-1:0] w_col_next;

  assign w_base_calc = CALC_W'(BASE_ADDR)
                     + CALC_W'(feature_idx) * CALC_W'(ARRAY_SIZE * ARRAY_SIZE)
                     + CALC_W'(feature_row) * CALC_W'(ARRAY_SIZE);
  assign w_base      = AW'(w_base_calc);

  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_base = r_fifo_base[r_rd_ptr];

  assign w_xfer     = ram_we && ram_ready;
  assign w_last     = (r_col == LAST_COL);
  assign w_col_next = r_col + 1'b1;
  // Popping on the final word keeps consecutive rows free of idle cycles.
  assign w_pop  = (r_count != 2'd0) &&
                  ((r_state == ST_IDLE) || ((r_state == ST_WRITE) && w_xfer && w_last));
  assign w_full = (r_count == 2'd2);
  assign w_push = valid && (!w_full || w_pop);
  assign w_drop = valid && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 2'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_WRITE;
        end else if (r_fin_pending) begin
          w_state_next = ST_FIN;
        end
      end
      ST_WRITE: begin
        if (w_xfer && w_last && !w_pop) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Row storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= feature_output;
      r_fifo_base[r_wr_ptr] <= w_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_count       <= 2'd0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_shift       <= '0;
      r_row_base    <= '0;
      r_col         <= '0;
      r_fin_pending <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_data      <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      write_fin     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      busy      <= (w_count_next != 2'd0) || (w_state_next != ST_IDLE);
      write_fin <= (w_state_next == ST_FIN);

      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end

      if (image_calc_fin) begin
        r_fin_pending <= 1'b1;
      end else if (r_state == ST_FIN) begin
        r_fin_pending <= 1'b0;
      end

      // Shift register holds the words still to be presented after ram_data.
      if (w_pop) begin
        r_shift    <= w_head_data << DW;
        r_row_base <= w_head_base;
        r_col      <= '0;
        ram_we     <= 1'b1;
        ram_addr   <= w_head_base;
        ram_data   <= w_head_data[ROW_W-1 -: DW];
      end else if (w_xfer) begin
        if (w_last) begin
          ram_we <= 1'b0;
        end else begin
          r_col    <= w_col_next;
          r_shift  <= r_shift << DW;
          ram_addr <= r_row_base + AW'(w_col_next);
          ram_data <= r_shift[ROW_W-1 -: DW];
        end
      end
    end
  end

endmodule

`default_nettype wire
